// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type, counter-width helper and 50 MHz default timings for multi_key_debounce
package key_pkg;
  typedef enum logic [2:0] {IDLE, PRESS_WAIT, HELD, LONG, RELEASE_WAIT} key_state_e;
  localparam int WIPE_TIME_DEF   = 1_000_000;
  localparam int LONG_TIME_DEF   = 50_000_000;
  localparam int REPEAT_TIME_DEF = 10_000_000;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/key_channel.sv
// key_channel: synchroniser, debounce FSM and hold/repeat timers for one key
// Ports: clk, rst (async, active high), key_i raw pin; level_o debounced pressed level,
// press_o/release_o/repeat_o one-cycle strobes, long_o long-press level.
// Optional macro KEY_REPEAT_EN compiles in the auto-repeat counter; otherwise repeat_o is 0.
module key_channel
  import key_pkg::*;
#(
  parameter int WIPE_TIME   = WIPE_TIME_DEF,
  parameter int LONG_TIME   = LONG_TIME_DEF,
  parameter int REPEAT_TIME = REPEAT_TIME_DEF,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);
  localparam int CW = cnt_width(WIPE_TIME, LONG_TIME, REPEAT_TIME);
  localparam logic [CW-1:0] WIPE_END = CW'(WIPE_TIME - 1);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_TIME - 1);
  localparam logic IDLE_LVL = 1'(ACTIVE_LOW);
  logic [1:0] sync_q;
  logic pressed_s;
  key_state_e state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d, hcnt_q, hcnt_d;
  logic long_q, long_d, press_q, press_d, release_q, release_d;
  // Synchroniser resets to the released pin level so reset release never looks like a press
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= {2{IDLE_LVL}};
    else sync_q <= {sync_q[0], key_i};
  assign pressed_s = sync_q[1] ^ IDLE_LVL;
  // Counters only advance below their terminal value, so they saturate rather than wrap
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    hcnt_d    = hcnt_q;
    long_d    = long_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: if (pressed_s) begin
        state_d = PRESS_WAIT;
        wcnt_d  = '0;
      end
      PRESS_WAIT:
        if (!pressed_s) state_d = IDLE;
        else if (wcnt_q == WIPE_END) begin
          state_d = HELD;
          press_d = 1'b1;
          hcnt_d  = '0;
        end else wcnt_d = wcnt_q + CW'(1);
      HELD:
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          wcnt_d  = '0;
        end else if (hcnt_q == LONG_END) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else hcnt_d = hcnt_q + CW'(1);
      LONG: if (!pressed_s) begin
        state_d = RELEASE_WAIT;
        wcnt_d  = '0;
      end
      // A bounce back to pressed resumes the prior state; long_q still tells which one
      RELEASE_WAIT:
        if (pressed_s) state_d = long_q ? LONG : HELD;
        else if (wcnt_q == WIPE_END) begin
          state_d   = IDLE;
          release_d = 1'b1;
          long_d    = 1'b0;
        end else wcnt_d = wcnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      hcnt_q    <= '0;
      long_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      hcnt_q    <= hcnt_d;
      long_q    <= long_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  assign level_o   = (state_q == HELD) || (state_q == LONG) || (state_q == RELEASE_WAIT);
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_END = CW'(REPEAT_TIME - 1);
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic repeat_q, repeat_d;
  // First strobe coincides with LONG entry; the phase is frozen while in RELEASE_WAIT
  always_comb begin
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    if (state_q == HELD && state_d == LONG) begin
      repeat_d = 1'b1;
      rcnt_d   = '0;
    end else if (state_q == LONG && state_d == LONG) begin
      repeat_d = (rcnt_q == REP_END);
      rcnt_d   = (rcnt_q == REP_END) ? '0 : rcnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      repeat_q <= repeat_d;
    end
  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif
endmodule

// File: rtl/multi_key_debounce.sv
// multi_key_debounce: NUM_KEYS independent debounced push-button channels
// Ports: clk, rst (async, active high), key_in raw pins; key_level debounced levels,
// key_press/key_release/key_repeat one-cycle strobes, key_long long-press levels.
// Optional macro KEY_REPEAT_EN enables auto-repeat strobes on key_repeat.
module multi_key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int WIPE_TIME   = WIPE_TIME_DEF,
  parameter int LONG_TIME   = LONG_TIME_DEF,
  parameter int REPEAT_TIME = REPEAT_TIME_DEF,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .WIPE_TIME  (WIPE_TIME),
      .LONG_TIME  (LONG_TIME),
      .REPEAT_TIME(REPEAT_TIME),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_i    (key_in[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .long_o   (key_long[i]),
      .repeat_o (key_repeat[i])
    );
  end
endmodule

// File: tb/tb_multi_key_debounce.sv
// tb_multi_key_debounce: directed + random bench for multi_key_debounce against a run-length reference model
module tb_multi_key_debounce;
  localparam int N = 4, W = 8, L = 40, R = 10, AL = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] key_in = {N{1'b1}};
  logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;
  int errs = 0, checks = 0;
  logic [N-1:0] p1, p2, m_lvl, m_prs, m_rel, m_lng, m_rep;
  int run[N], tk[N], rt[N], hl[N];
  int c;
  logic act;

  multi_key_debounce #(
    .NUM_KEYS(N), .WIPE_TIME(W), .LONG_TIME(L), .REPEAT_TIME(R), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long), .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // kind: 0 press, 1 release, 2 long; c = index of first tick showing the event, -1 if none
  task automatic meas(input int k, input int kind, input int base, input int lim, output int r);
    r = -1;
    for (int i = base; i <= lim && r < 0; i++) begin
      tick();
      if ((kind == 0 ? key_press[k] : kind == 1 ? key_release[k] : key_long[k]) === 1'b1) r = i;
    end
  endtask

  // Reference: the key's synchronised sample is the pin two edges ago. The debounced level flips
  // once W+1 consecutive samples disagree with it. Hold time accrues on edges where the key was
  // pressed on this and the previous sample; L such edges give long, then every R a repeat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 = {N{1'(AL)}};
      p2 = {N{1'(AL)}};
      m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0; m_rep = '0;
      for (int k = 0; k < N; k++) begin run[k] = 0; tk[k] = 0; rt[k] = 0; end
    end else begin
      for (int k = 0; k < N; k++) begin
        logic s, elig;
        s = p2[k] ^ 1'(AL);
        m_prs[k] = 1'b0; m_rel[k] = 1'b0; m_rep[k] = 1'b0;
        elig = m_lvl[k] && s && run[k] == 0;
        run[k] = (s != m_lvl[k]) ? run[k] + 1 : 0;
        if (run[k] == W + 1) begin
          m_lvl[k] = ~m_lvl[k];
          run[k] = 0;
          if (m_lvl[k]) begin m_prs[k] = 1'b1; tk[k] = 0; end
          else begin m_rel[k] = 1'b1; m_lng[k] = 1'b0; end
        end else if (elig) begin
          if (!m_lng[k]) begin
            tk[k]++;
            if (tk[k] == L) begin m_lng[k] = 1'b1; m_rep[k] = 1'b1; rt[k] = 0; end
          end else begin
            rt[k]++;
            if (rt[k] == R) begin m_rep[k] = 1'b1; rt[k] = 0; end
          end
        end
      end
      p2 = p1;
      p1 = key_in;
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("level", 32'(key_level), 32'(m_lvl));
    chk("press", 32'(key_press), 32'(m_prs));
    chk("release", 32'(key_release), 32'(m_rel));
    chk("long", 32'(key_long), 32'(m_lng));
`ifdef KEY_REPEAT_EN
    chk("repeat", 32'(key_repeat), 32'(m_rep));
`else
    chk("repeat_off", 32'(key_repeat), 32'd0);
`endif
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_state", 32'({key_level, key_press, key_release, key_long, key_repeat}), 32'd0);
    // Clean press/release of key 0
    key_in[0] = 1'b0;
    meas(0, 0, 0, 30, c);
    chk("press_lat0", c, W + 2);
    chk("level0_up", 32'(key_level[0]), 32'd1);
    tick();
    chk("press0_one_cycle", 32'(key_press[0]), 32'd0);
    repeat (5) tick();
    key_in[0] = 1'b1;
    meas(0, 1, 0, 30, c);
    chk("release_lat0", c, W + 2);
    chk("level0_down", 32'(key_level[0]), 32'd0);
    // Key 1 bounce never settles long enough
    act = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) key_in[1] = ~key_in[1];
      tick();
      act |= key_press[1] | key_level[1] | key_release[1];
    end
    key_in[1] = 1'b1;
    repeat (15) begin
      tick();
      act |= key_press[1] | key_level[1] | key_release[1];
    end
    chk("bounce_quiet1", 32'(act), 32'd0);
    // Key 2 long hold
    key_in[2] = 1'b0;
    meas(2, 0, 0, 30, c);
    chk("press_lat2", c, W + 2);
    meas(2, 2, 1, 60, c);
    chk("long_lat2", c, L);
`ifdef KEY_REPEAT_EN
    chk("repeat_at_long2", 32'(key_repeat[2]), 32'd1);
`else
    chk("repeat_at_long2_off", 32'(key_repeat[2]), 32'd0);
`endif
    repeat (60) tick();
    key_in[2] = 1'b1;
    meas(2, 1, 0, 30, c);
    chk("release_lat2", c, W + 2);
    chk("long2_cleared", 32'(key_long[2]), 32'd0);
    // All keys at once
    key_in = '0;
    c = -1;
    for (int i = 0; i < 30 && c < 0; i++) begin
      tick();
      if (key_press !== '0) c = i;
    end
    chk("all_press_lat", c, W + 2);
    chk("all_press", 32'(key_press), 32'hF);
    key_in = '1;
    repeat (15) tick();
    // Reset while key 3 is in long-press
    key_in[3] = 1'b0;
    meas(3, 2, 0, 80, c);
    chk("long3_reached", 32'(c >= 0), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_clear", 32'({key_level, key_press, key_release, key_long, key_repeat}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    meas(3, 0, 0, 30, c);
    chk("press_after_rst3", c, W + 2);
    key_in[3] = 1'b1;
    repeat (15) tick();
    // Random mix of bounces and holds on all keys, checked by the model every cycle
    for (int k = 0; k < N; k++) hl[k] = 0;
    repeat (2000) begin
      for (int k = 0; k < N; k++) begin
        if (hl[k] == 0) begin
          key_in[k] = ~key_in[k];
          hl[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(9, 70));
        end else hl[k]--;
      end
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/multi_key_debounce.md
# multi_key_debounce

Parametrised N-channel push-button conditioner: one synchroniser, debounce timer and press state machine per key. Each channel produces a clean level plus single-cycle press/release strobes, a long-press flag and optional auto-repeat strobes. It sits between the board buttons and the clock/calendar control logic (mode, move, add, switch), and is sized for any key count with one instance.

## Interface
- `NUM_KEYS`, 4: number of independent key channels (≥1).
- `WIPE_TIME`, 1_000_000: debounce stability window in clk cycles (20 ms at 50 MHz); ≥2.
- `LONG_TIME`, 50_000_000: hold time from `key_press` to `key_long` assertion (1 s); > `WIPE_TIME`.
- `REPEAT_TIME`, 10_000_000: auto-repeat strobe period once long-press is reached (200 ms); ≥2.
- `ACTIVE_LOW`, 1: 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed.
- `clk`  input  1  system clock, 50 MHz.
- `rst`  input  1  asynchronous, active-high reset.
- `key_in`  input  NUM_KEYS  raw asynchronous key pins.
- `key_level`  output  NUM_KEYS  debounced state, 1 = pressed (polarity-normalised).
- `key_press`  output  NUM_KEYS  1-cycle strobe on debounced press.
- `key_release`  output  NUM_KEYS  1-cycle strobe on debounced release.
- `key_long`  output  NUM_KEYS  level, high while held past `LONG_TIME`.
- `key_repeat`  output  NUM_KEYS  1-cycle auto-repeat strobe.

## Operation
- Per channel: 2-flop synchroniser, then XOR with `ACTIVE_LOW` → internal `pressed_s`.
- Per-channel FSM states: IDLE, PRESS_WAIT, HELD, LONG, RELEASE_WAIT.
- IDLE: `pressed_s`=1 → PRESS_WAIT, counter cleared.
- PRESS_WAIT: counter increments while `pressed_s`=1; any 0 sample → IDLE (bounce, no strobe). Counter reaching `WIPE_TIME-1` → HELD, `key_press` strobe, `key_level`←1.
- HELD: hold counter increments; `pressed_s`=0 → RELEASE_WAIT. Hold counter reaching `LONG_TIME-1` → LONG, `key_long`←1.
- LONG: with repeat enabled, repeat counter fires `key_repeat` every `REPEAT_TIME` cycles, first strobe on LONG entry; `pressed_s`=0 → RELEASE_WAIT.
- RELEASE_WAIT: counter increments while `pressed_s`=0; any 1 sample → back to prior state (HELD or LONG, its timers continue, no strobe). Reaching `WIPE_TIME-1` → IDLE, `key_release` strobe, `key_level`←0, `key_long`←0.
- Channels fully independent; simultaneous presses on all channels produce strobes in the same cycle.
- Counters saturate; never wrap. Width = clog2 of the largest parameter.

## Timing
- Reset: all outputs 0, all FSMs IDLE, counters 0, synchroniser flops loaded with the released level (no spurious press on reset release).
- Press latency: clean edge sampled at cycle 0 → `key_press` high in cycle 0+2+`WIPE_TIME`, for exactly 1 cycle; `key_level` rises in the same cycle.
- Release latency identical: `key_release` 2+`WIPE_TIME` cycles after a clean release.
- `key_long` rises `LONG_TIME` cycles after `key_press`; first `key_repeat` in the same cycle; subsequent every `REPEAT_TIME`.
- A press shorter than `WIPE_TIME` stable cycles produces no output activity.
- `rst` mid-operation: immediate return to reset values; a key still held after reset release is debounced as a new press.

## Configuration
- `KEY_REPEAT_EN` defined: repeat counter and `key_repeat` generation compiled in.
- Not defined: repeat logic removed, `key_repeat` tied to 0, LONG behaves as a plain hold state; all other timing unchanged.

## Structure
- Shared package `key_pkg`: FSM state enum (IDLE, PRESS_WAIT, HELD, LONG, RELEASE_WAIT), counter-width function/constant, default timing constants for 50 MHz.
- One sub-module `key_channel`: synchroniser + FSM + counters for one key; top generates `NUM_KEYS` instances and concatenates outputs.

## Test plan
- Bench params `WIPE_TIME`=8, `LONG_TIME`=40, `REPEAT_TIME`=10, `NUM_KEYS`=4, `ACTIVE_LOW`=1.
- Clean press of key 0 at cycle 0 → `key_press[0]` 1-cycle pulse at cycle 10, `key_level[0]`=1; release → `key_release[0]` 10 cycles later.
- Key 1 bounces 0/1 every 3 cycles for 30 cycles, then released → no strobes, `key_level[1]` stays 0.
- Key 2 held 100 cycles → `key_long[2]` at press+40, `key_repeat[2]` at press+40, +50, +60…; cleared on release strobe.
- All four keys pressed in the same cycle → four `key_press` bits high in one cycle.
- `rst` pulsed while key 3 in LONG → all outputs 0 immediately; key still held → new `key_press[3]` 10 cycles after reset deasserts.
- Build without `KEY_REPEAT_EN`, repeat the hold test → `key_long` identical, `key_repeat` constant 0.
